// File: rtl/inv_key_sched_if.sv
// Handshake and S-box bundle for the reverse AES-128 key-schedule sequencer.
// rk is transferred on a rising clk edge where rk_valid && rk_ready; rk_valid
// and rk stay stable until then. sub_out must be SubWord(sub_in) in the same cycle.
interface inv_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] rk;
  logic         rk_valid;
  logic [3:0]   rnd;
  logic [7:0]   rc;
  logic         first_rnd;
  logic         final_rnd;
  logic         busy;
  logic         done;
  logic         dbg_state;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;

  modport master (
    output start, key_in, rk_ready, sub_out,
    input  rk, rk_valid, rnd, rc, first_rnd, final_rnd, busy, done, dbg_state, sub_in
  );

  modport slave (
    input  start, key_in, rk_ready, sub_out,
    output rk, rk_valid, rnd, rc, first_rnd, final_rnd, busy, done, dbg_state, sub_in
  );
endinterface

// File: rtl/inv_key_sched.sv
// Reverse AES-128 key schedule: emits round keys 10..0 from the round-10 key,
// rebuilding each previous key through an external combinational S-box.
module inv_key_sched (
    input  logic            clk,
    input  logic            rst,
    inv_key_sched_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t       state;
    logic [127:0] rk;
    logic [3:0]   rnd;
    logic [7:0]   rc;
    logic         rk_valid;
    logic         done;

    logic [31:0]  w0, w1, w2, w3, t;
    logic         accept;

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];
    assign t  = w3 ^ w2;   // previous key's w3, which fed the forward g() step

    assign accept = rk_valid && bus.rk_ready;

    // Undo xtime: a set LSB means the forward step reduced by 0x1b.
    function automatic logic [7:0] inv_xtime(input logic [7:0] v);
        return v[0] ? (((v ^ 8'h1b) >> 1) | 8'h80) : (v >> 1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rk       <= '0;
            rnd      <= 4'd0;
            rc       <= 8'h36;
            rk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rk       <= bus.key_in;
                        rnd      <= 4'd10;
                        rc       <= 8'h36;
                        rk_valid <= 1'b1;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (accept) begin
                        if (rnd != 4'd0) begin
                            rk  <= {w0 ^ bus.sub_out ^ {rc, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};
                            rnd <= rnd - 4'd1;
                            rc  <= inv_xtime(rc);
                        end else begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rk        = rk;
    assign bus.rk_valid  = rk_valid;
    assign bus.rnd       = rnd;
    assign bus.rc        = rc;
    assign bus.done      = done;
    assign bus.busy      = (state != IDLE);
    assign bus.dbg_state = state;
    assign bus.first_rnd = rk_valid && (rnd == 4'd10);
    assign bus.final_rnd = rk_valid && (rnd == 4'd0);
    assign bus.sub_in    = {t[23:0], t[31:24]};

endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched: behavioural S-box and forward AES-128 key expansion
// provide the expected round keys, which the DUT must emit in reverse order.
module tb_inv_key_sched;

  logic clk = 1'b0;
  logic rst;

  inv_key_sched_if bus ();

  inv_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_q[$];
  logic [127:0] mdl_rk [0:10];
  logic [7:0]   rcon_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq  = x;
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    if (x == 8'h00) inv = 8'h00;
    s = inv ^ 8'h63;
    for (int k = 1; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    logic [31:0] o;
    for (int b = 0; b < 4; b++) o[8*b +: 8] = sbox(v[8*b +: 8]);
    return o;
  endfunction

  always_comb bus.sub_out = sub_word(bus.sub_in);

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i/4], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back(mdl_rk[r]);
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- drivers ----------------
  task automatic start_key(input logic [127:0] k);
    bus.key_in = k;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int ph = 0; ph < 2; ph++) begin
      n_cmp++; if (bus.rk_valid !== 1'b0) begin n_err++; $display("FAIL reset_rk_valid: got %0b want 0", bus.rk_valid); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
      n_cmp++; if (bus.rnd !== 4'd0) begin n_err++; $display("FAIL reset_rnd: got %0d want 0", bus.rnd); end
      n_cmp++; if (bus.rc !== 8'h36) begin n_err++; $display("FAIL reset_rc: got %h want 36", bus.rc); end
      n_cmp++; if (bus.rk !== 128'h0) begin n_err++; $display("FAIL reset_rk: got %h want 0", bus.rk); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", bus.done); end
      n_cmp++; if ({bus.first_rnd, bus.final_rnd} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {bus.first_rnd, bus.final_rnd}); end
      n_cmp++; if (bus.sub_in !== 32'h0) begin n_err++; $display("FAIL reset_sub_in: got %h want 0", bus.sub_in); end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_fips();
    logic [127:0] k10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    logic [31:0]  tw;
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    bus.rk_ready = 1'b1;
    start_key(k10);
    tw = k10[31:0] ^ k10[63:32];
    n_cmp++; if (bus.sub_in !== {tw[23:0], tw[31:24]}) begin n_err++; $display("FAIL fips_sub_in: got %h want %h", bus.sub_in, {tw[23:0], tw[31:24]}); end
    for (int r = 10; r >= 0; r--) begin
      n_cmp++; if (bus.rk_valid !== 1'b1) begin n_err++; $display("FAIL fips_valid r%0d: got %0b want 1", r, bus.rk_valid); end
      n_cmp++; if (bus.rnd !== 4'(r)) begin n_err++; $display("FAIL fips_rnd: got %0d want %0d", bus.rnd, r); end
      n_cmp++; if (bus.rk !== mdl_rk[r]) begin n_err++; $display("FAIL fips_rk r%0d: got %h want %h", r, bus.rk, mdl_rk[r]); end
      if (r >= 1) begin
        n_cmp++; if (bus.rc !== rcon_tab[r]) begin n_err++; $display("FAIL fips_rc r%0d: got %h want %h", r, bus.rc, rcon_tab[r]); end
      end
      n_cmp++; if (bus.first_rnd !== (r == 10)) begin n_err++; $display("FAIL fips_first r%0d: got %0b want %0b", r, bus.first_rnd, r == 10); end
      n_cmp++; if (bus.final_rnd !== (r == 0)) begin n_err++; $display("FAIL fips_final r%0d: got %0b want %0b", r, bus.final_rnd, r == 0); end
      if (r == 10) begin
        n_cmp++; if (bus.rk !== k10) begin n_err++; $display("FAIL fips_k10: got %h want %h", bus.rk, k10); end
      end
      if (r == 9) begin
        n_cmp++; if (bus.rk !== 128'hac7766f319fadc2128d12941575c006e) begin n_err++; $display("FAIL fips_k9: got %h want ac7766f319fadc2128d12941575c006e", bus.rk); end
      end
      if (r == 0) begin
        n_cmp++; if (bus.rk !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin n_err++; $display("FAIL fips_k0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", bus.rk); end
      end
      @(negedge clk);
    end
    n_cmp++; if ({bus.done, bus.rk_valid} !== 2'b10) begin n_err++; $display("FAIL fips_done: got done/valid %b want 10", {bus.done, bus.rk_valid}); end
    @(negedge clk);
    n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_err++; $display("FAIL fips_done_pulse: got done/busy %b want 00", {bus.done, bus.busy}); end
  endtask

  task automatic test_backpressure();
    int exp_rnd = 10;
    bit stalled = 1'b0;
    bit fin = 1'b0;
    logic [127:0] h_rk;
    logic [7:0]   h_rc;
    model_expand(rand_key());
    bus.rk_ready = 1'b1;
    start_key(mdl_rk[10]);
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      n_cmp++; if (bus.rk_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %0b want 1", bus.rk_valid); end
      n_cmp++; if (bus.rk !== exp_q[0]) begin n_err++; $display("FAIL bp_rk r%0d: got %h want %h", exp_rnd, bus.rk, exp_q[0]); end
      n_cmp++; if (bus.rnd !== 4'(exp_rnd)) begin n_err++; $display("FAIL bp_rnd: got %0d want %0d", bus.rnd, exp_rnd); end
      if (exp_rnd == 6 && !stalled) begin
        bus.rk_ready = 1'b0;
        h_rk = bus.rk;
        h_rc = bus.rc;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_cmp++; if ({bus.rk_valid, bus.rnd} !== {1'b1, 4'd6}) begin n_err++; $display("FAIL bp_hold_vr: got %b want 10110", {bus.rk_valid, bus.rnd}); end
          n_cmp++; if (bus.rk !== h_rk || bus.rc !== h_rc) begin n_err++; $display("FAIL bp_hold_key: got %h/%h want %h/%h", bus.rk, bus.rc, h_rk, h_rc); end
        end
        stalled = 1'b1;
        bus.rk_ready = 1'b1;
      end
      void'(exp_q.pop_front());
      exp_rnd--;
      if (exp_q.size() == 0) begin
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %0b want 1", bus.done); end
        fin = 1'b1;
      end
      @(negedge clk);
    end
    if (!fin) begin n_err++; n_cmp++; $display("FAIL bp_timeout: got %0d keys left want 0", exp_q.size()); end
  endtask

  task automatic test_start_ignored();
    int exp_rnd = 10;
    bit fin = 1'b0;
    model_expand(rand_key());
    bus.rk_ready = 1'b1;
    start_key(mdl_rk[10]);
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      n_cmp++; if (bus.rk !== exp_q[0] || bus.rnd !== 4'(exp_rnd)) begin n_err++; $display("FAIL ign_rk r%0d: got %h/%0d want %h/%0d", exp_rnd, bus.rk, bus.rnd, exp_q[0], exp_rnd); end
      bus.start  = (exp_rnd == 4 || exp_rnd == 0);
      bus.key_in = rand_key();
      void'(exp_q.pop_front());
      exp_rnd--;
      if (exp_q.size() == 0) fin = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    n_cmp++; if ({bus.done, bus.rk_valid} !== 2'b10) begin n_err++; $display("FAIL ign_done: got done/valid %b want 10", {bus.done, bus.rk_valid}); end
    @(negedge clk);
    n_cmp++; if ({bus.busy, bus.rk_valid} !== 2'b00) begin n_err++; $display("FAIL ign_reload: got busy/valid %b want 00", {bus.busy, bus.rk_valid}); end
  endtask

  task automatic test_reset_mid_run();
    model_expand(rand_key());
    bus.rk_ready = 1'b1;
    start_key(mdl_rk[10]);
    for (int r = 10; r > 3; r--) @(negedge clk);
    n_cmp++; if (bus.rnd !== 4'd3) begin n_err++; $display("FAIL rmr_rnd: got %0d want 3", bus.rnd); end
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    n_cmp++; if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000) begin n_err++; $display("FAIL rmr_flags: got valid/busy/done %b want 000", {bus.rk_valid, bus.busy, bus.done}); end
    n_cmp++; if (bus.rnd !== 4'd0 || bus.rc !== 8'h36) begin n_err++; $display("FAIL rmr_regs: got rnd %0d rc %h want 0 36", bus.rnd, bus.rc); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rmr_no_done: got %0b want 0", bus.done); end
    model_expand(rand_key());
    start_key(mdl_rk[10]);
    for (int r = 10; r >= 0; r--) begin
      n_cmp++; if (bus.rk !== mdl_rk[r] || bus.rnd !== 4'(r)) begin n_err++; $display("FAIL rmr_rk r%0d: got %h/%0d want %h", r, bus.rk, bus.rnd, mdl_rk[r]); end
      @(negedge clk);
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL rmr_done: got %0b want 1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] kb;
    model_expand(rand_key());
    bus.rk_ready = 1'b1;
    start_key(mdl_rk[10]);
    for (int r = 10; r >= 0; r--) @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %0b want 1", bus.done); end
    model_expand(rand_key());
    kb = mdl_rk[10];
    start_key(kb);
    n_cmp++; if ({bus.rk_valid, bus.rnd, bus.rc} !== {1'b1, 4'd10, 8'h36}) begin n_err++; $display("FAIL b2b_hdr: got %b want 1101000110110", {bus.rk_valid, bus.rnd, bus.rc}); end
    for (int r = 10; r >= 0; r--) begin
      n_cmp++; if (bus.rk !== mdl_rk[r]) begin n_err++; $display("FAIL b2b_rk r%0d: got %h want %h", r, bus.rk, mdl_rk[r]); end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int exp_rnd = 10;
      bit fin = 1'b0;
      model_expand(rand_key());
      bus.rk_ready = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start_key(mdl_rk[10]);
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
        n_cmp++; if (bus.rk_valid !== 1'b1) begin n_err++; $display("FAIL rnd_valid: got %0b want 1", bus.rk_valid); end
        n_cmp++; if (bus.rk !== exp_q[0] || bus.rnd !== 4'(exp_rnd)) begin n_err++; $display("FAIL rnd_rk r%0d: got %h/%0d want %h", exp_rnd, bus.rk, bus.rnd, exp_q[0]); end
        if (exp_rnd >= 1) begin
          n_cmp++; if (bus.rc !== rcon_tab[exp_rnd]) begin n_err++; $display("FAIL rnd_rc r%0d: got %h want %h", exp_rnd, bus.rc, rcon_tab[exp_rnd]); end
        end
        bus.rk_ready = ($urandom_range(0, 2) != 0);
        if (bus.rk_ready) begin
          void'(exp_q.pop_front());
          exp_rnd--;
          if (exp_q.size() == 0) begin
            @(negedge clk);
            n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL rnd_done: got %0b want 1", bus.done); end
            fin = 1'b1;
          end
        end
        @(negedge clk);
      end
      if (!fin) begin n_err++; n_cmp++; $display("FAIL rnd_timeout: got %0d keys left want 0", exp_q.size()); end
    end
    bus.rk_ready = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_fips();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
